// File: rtl/split_adder_precompute.sv
// -----------------------------------------------------------------------------
// split_adder_precompute
//
// Front end of the pipelined SplitAdder. The operands are cut into SS-bit
// segments (the last one is shorter when IO is not a multiple of SS). For
// each segment this block computes two candidate sums and carry-outs: one
// assuming the segment's carry-in is 0 and one assuming it is 1. The
// downstream SplitAdderSelector picks between them once the real segment
// carries are known. Results are registered behind a valid/ready handshake
// with a two-entry skid buffer, so the block sustains one bundle per cycle.
//
// Build option:
//   SPLIT_ADDER_SUB_EN  adds a 'sub' input. With sub=1 the block computes
//                       a - b (b inverted, cin_o forced to 1). Without the
//                       macro the block only adds and cin_o = cin_i.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-high reset
//   in_valid   a, b, cin_i (and sub) are valid this cycle
//   in_ready   block accepts an input this cycle
//   a, b       IO-bit operands
//   cin_i      global carry-in of the add
//   sub        (SPLIT_ADDER_SUB_EN only) subtract instead of add
//   out_valid  candidate bundle valid
//   out_ready  selector stage accepts the bundle
//   psum0      segment sums, segment carry-in 0
//   psum1      segment sums, segment carry-in 1
//   cout0      segment carry-outs, segment carry-in 0 (one bit per segment)
//   cout1      segment carry-outs, segment carry-in 1
//   cin_o      registered carry-in for the selector
// -----------------------------------------------------------------------------
module split_adder_precompute #(
    parameter int IO = 512,
    parameter int SS = (($clog2(IO) >> 2) > 0) ? (1 << ($clog2(IO) >> 2))
                                               : (1 << ($clog2(IO) >> 1))
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IO-1:0]       a,
    input  logic [IO-1:0]       b,
    input  logic                cin_i,
`ifdef SPLIT_ADDER_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IO-1:0]       psum0,
    output logic [IO-1:0]       psum1,
    output logic [IO/SS + ((IO%SS) != 0 ? 1 : 0)-1:0] cout0,
    output logic [IO/SS + ((IO%SS) != 0 ? 1 : 0)-1:0] cout1,
    output logic                cin_o
);

    localparam int N_PARTS = IO/SS + ((IO%SS) != 0 ? 1 : 0);

    // Occupancy of the M (output) / S (skid) register pair.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    typedef struct packed {
        logic [IO-1:0]      psum0;
        logic [IO-1:0]      psum1;
        logic [N_PARTS-1:0] cout0;
        logic [N_PARTS-1:0] cout1;
        logic               cin;
    } bundle_t;

    logic [1:0] state;
    bundle_t    m_reg;
    bundle_t    s_reg;
    bundle_t    nxt;

    logic       push;
    logic       pop;

    // ------------------------------------------------------------------
    // Operand conditioning: subtraction is a + ~b + 1, so the inversion
    // happens before segmentation and the +1 travels on the carry-in.
    // ------------------------------------------------------------------
    logic [IO-1:0] b_eff;
    logic          cin_eff;

`ifdef SPLIT_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin_i;
`else
    assign b_eff   = b;
    assign cin_eff = cin_i;
`endif

    // ------------------------------------------------------------------
    // Per-segment candidate sums. Each adder is one bit wider than its
    // segment so the carry-out is never truncated.
    // ------------------------------------------------------------------
    wire [IO-1:0]      seg_sum0;
    wire [IO-1:0]      seg_sum1;
    wire [N_PARTS-1:0] seg_cout0;
    wire [N_PARTS-1:0] seg_cout1;

    for (genvar j = 0; j < N_PARTS; j++) begin : g_seg
        localparam int LO = j * SS;
        localparam int HI = ((j + 1) * SS > IO) ? IO : (j + 1) * SS;
        localparam int W  = HI - LO;

        logic [W:0] s0;
        logic [W:0] s1;

        assign s0 = {1'b0, a[HI-1:LO]} + {1'b0, b_eff[HI-1:LO]};
        assign s1 = {1'b0, a[HI-1:LO]} + {1'b0, b_eff[HI-1:LO]} + (W+1)'(1);

        assign seg_sum0[HI-1:LO] = s0[W-1:0];
        assign seg_sum1[HI-1:LO] = s1[W-1:0];
        assign seg_cout0[j]      = s0[W];
        assign seg_cout1[j]      = s1[W];
    end

    assign nxt.psum0 = seg_sum0;
    assign nxt.psum1 = seg_sum1;
    assign nxt.cout0 = seg_cout0;
    assign nxt.cout1 = seg_cout1;
    assign nxt.cin   = cin_eff;

    // ------------------------------------------------------------------
    // Handshake. in_ready depends only on registered state, so there is
    // no combinational path from out_ready back to in_ready.
    // ------------------------------------------------------------------
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the data registers are reset as well, because the outputs are
    // required to read zero during and after reset; they otherwise load
    // only on a transfer, so idle cycles cause no toggling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            m_reg <= '0;
            s_reg <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        m_reg <= nxt;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        // Reload M in place: no bubble between bundles.
                        m_reg <= nxt;
                    end else if (push) begin
                        s_reg <= nxt;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        m_reg <= s_reg;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign psum0 = m_reg.psum0;
    assign psum1 = m_reg.psum1;
    assign cout0 = m_reg.cout0;
    assign cout1 = m_reg.cout1;
    assign cin_o = m_reg.cin;

endmodule
